// File: rtl/oled_power_sequencer.sv
// ============================================================================
// oled_power_sequencer : OLED panel rail / reset / command power sequencing FSM
// Revision: 1.0
// ============================================================================
`default_nettype none

module oled_power_sequencer #(
   parameter int                     CLOCK_COUNT_W = 32,
   parameter logic [CLOCK_COUNT_W-1:0] T_PMOD_US   = 20000,
   parameter logic [CLOCK_COUNT_W-1:0] T_RES_US    = 3,
   parameter logic [CLOCK_COUNT_W-1:0] T_VCC_US    = 25000,
   parameter logic [CLOCK_COUNT_W-1:0] T_DISPON_US = 100000,
   parameter logic [CLOCK_COUNT_W-1:0] T_VCCOFF_US = 400000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     stop,
   output logic                     timer_update_match,
   output logic [CLOCK_COUNT_W-1:0] timer_match,
   input  logic                     timer_done,
   output logic                     cmd_req,
   output logic [1:0]               cmd_sel,
   input  logic                     cmd_done,
   output logic                     pmoden,
   output logic                     vccen,
   output logic                     res_n,
   output logic                     ready,
   output logic                     busy
);

   typedef enum logic [3:0] {
      S_OFF         = 4'd0,
      S_PMOD_WAIT   = 4'd1,
      S_RES_LOW     = 4'd2,
      S_RES_HIGH    = 4'd3,
      S_INIT_CMD    = 4'd4,
      S_VCC_WAIT    = 4'd5,
      S_DISPON_CMD  = 4'd6,
      S_DISPON_WAIT = 4'd7,
      S_READY       = 4'd8,
      S_DISPOFF_CMD = 4'd9,
      S_VCCOFF_WAIT = 4'd10
   } state_t;

   state_t                   state_q, state_d;
   logic                     stop_pending_q, stop_pending_d;
   logic                     tum_q;
   logic [CLOCK_COUNT_W-1:0] timer_match_q;
   logic                     cmd_req_q;
   logic [1:0]               cmd_sel_q;
   logic                     pmoden_q, vccen_q, res_n_q, ready_q, busy_q;

   logic                     w_expired;
   logic                     w_load;
   logic [CLOCK_COUNT_W-1:0] w_match;

   // A timer_done coinciding with the load strobe belongs to no live delay.
   assign w_expired = timer_done && !tum_q;

   always_comb begin
      state_d        = state_q;
      stop_pending_d = stop_pending_q;
      case (state_q)
         S_OFF:         if (start)      state_d = S_PMOD_WAIT;
         S_PMOD_WAIT:   if (w_expired)  state_d = S_RES_LOW;
         S_RES_LOW:     if (w_expired)  state_d = S_RES_HIGH;
         S_RES_HIGH:    if (w_expired)  state_d = S_INIT_CMD;
         S_INIT_CMD:    if (cmd_done)   state_d = S_VCC_WAIT;
         S_VCC_WAIT:    if (w_expired)  state_d = S_DISPON_CMD;
         S_DISPON_CMD:  if (cmd_done)   state_d = S_DISPON_WAIT;
         S_DISPON_WAIT: if (w_expired)  state_d = S_READY;
         S_READY: begin
            if (stop || stop_pending_q) begin
               state_d        = S_DISPOFF_CMD;
               stop_pending_d = 1'b0;
            end
         end
         S_DISPOFF_CMD: if (cmd_done)   state_d = S_VCCOFF_WAIT;
         S_VCCOFF_WAIT: if (w_expired)  state_d = S_OFF;
         default:                       state_d = S_OFF;
      endcase

      // Stop requests during power-up are deferred until READY is reached.
      if (stop && (state_q >= S_PMOD_WAIT) && (state_q <= S_DISPON_WAIT)) begin
         stop_pending_d = 1'b1;
      end
   end

   always_comb begin
      w_match = '0;
      case (state_d)
         S_PMOD_WAIT:   w_match = T_PMOD_US;
         S_RES_LOW:     w_match = T_RES_US;
         S_RES_HIGH:    w_match = T_RES_US;
         S_VCC_WAIT:    w_match = T_VCC_US;
         S_DISPON_WAIT: w_match = T_DISPON_US;
         S_VCCOFF_WAIT: w_match = T_VCCOFF_US;
         default:       w_match = '0;
      endcase
   end

   assign w_load = (state_d != state_q) && (w_match != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= S_OFF;
         stop_pending_q <= 1'b0;
         tum_q          <= 1'b0;
         timer_match_q  <= '0;
         cmd_req_q      <= 1'b0;
         cmd_sel_q      <= 2'd0;
         pmoden_q       <= 1'b0;
         vccen_q        <= 1'b0;
         res_n_q        <= 1'b1;
         ready_q        <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         stop_pending_q <= stop_pending_d;
         tum_q          <= w_load;
         timer_match_q  <= w_load ? w_match : '0;
         cmd_req_q      <= (state_d == S_INIT_CMD) || (state_d == S_DISPON_CMD) ||
                           (state_d == S_DISPOFF_CMD);
         cmd_sel_q      <= (state_d == S_DISPON_CMD)  ? 2'd1 :
                           (state_d == S_DISPOFF_CMD) ? 2'd2 : 2'd0;
         pmoden_q       <= (state_d != S_OFF);
         vccen_q        <= (state_d >= S_VCC_WAIT) && (state_d <= S_DISPOFF_CMD);
         res_n_q        <= (state_d != S_RES_LOW);
         ready_q        <= (state_d == S_READY);
         busy_q         <= (state_d != S_OFF) && (state_d != S_READY);
      end
   end

   assign timer_update_match = tum_q;
   assign timer_match        = timer_match_q;
   assign cmd_req            = cmd_req_q;
   assign cmd_sel            = cmd_sel_q;
   assign pmoden             = pmoden_q;
   assign vccen              = vccen_q;
   assign res_n              = res_n_q;
   assign ready              = ready_q;
   assign busy               = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_oled_power_sequencer.sv
// ============================================================================
// tb_oled_power_sequencer : directed bench with behavioural timer and SPI stub
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_oled_power_sequencer;

   localparam int US_CYCLES = 4;
   localparam int BUDGET    = 400;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        timer_update_match;
   logic [31:0] timer_match;
   logic        timer_done;
   logic        cmd_req;
   logic [1:0]  cmd_sel;
   logic        cmd_done;
   logic        pmoden, vccen, res_n, ready, busy;

   logic        tdone_m = 1'b0, spur_td = 1'b0;
   logic        cdone_m = 1'b0, spur_cd = 1'b0;
   int          tcnt = 0;
   int          ccnt = 0;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          loads[$];
   int          cmds[$];
   logic        prev_req = 1'b0;
   logic        res_low_seen = 1'b0;

   assign timer_done = tdone_m | spur_td;
   assign cmd_done   = cdone_m | spur_cd;

   always #5 clk = ~clk;

   oled_power_sequencer #(
      .CLOCK_COUNT_W (32),
      .T_PMOD_US     (32'd5),
      .T_RES_US      (32'd2),
      .T_VCC_US      (32'd7),
      .T_DISPON_US   (32'd9),
      .T_VCCOFF_US   (32'd11)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .start              (start),
      .stop               (stop),
      .timer_update_match (timer_update_match),
      .timer_match        (timer_match),
      .timer_done         (timer_done),
      .cmd_req            (cmd_req),
      .cmd_sel            (cmd_sel),
      .cmd_done           (cmd_done),
      .pmoden             (pmoden),
      .vccen              (vccen),
      .res_n              (res_n),
      .ready              (ready),
      .busy               (busy)
   );

   // Behavioural microsecond timer: one us lasts US_CYCLES clocks.
   always @(posedge clk) begin
      tdone_m <= 1'b0;
      if (!rst_n) begin
         tcnt <= 0;
      end else if (timer_update_match) begin
         tcnt <= int'(timer_match) * US_CYCLES;
      end else if (tcnt == 1) begin
         tcnt    <= 0;
         tdone_m <= 1'b1;
      end else if (tcnt != 0) begin
         tcnt <= tcnt - 1;
      end
   end

   // SPI command stub: answers a request after four clocks.
   always @(posedge clk) begin
      cdone_m <= 1'b0;
      if (cmd_req && !cdone_m) begin
         if (ccnt == 3) begin
            ccnt    <= 0;
            cdone_m <= 1'b1;
         end else begin
            ccnt <= ccnt + 1;
         end
      end else if (!cmd_req) begin
         ccnt <= 0;
      end
   end

   always @(negedge clk) begin
      if (timer_update_match) loads.push_back(int'(timer_match));
      if (cmd_req && !prev_req) cmds.push_back(int'(cmd_sel));
      if (!res_n) res_low_seen <= 1'b1;
      prev_req <= cmd_req;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit cond(input int sel);
      case (sel)
         0:       return ready;
         1:       return timer_update_match;
         2:       return timer_done;
         3:       return cmd_req;
         4:       return vccen;
         5:       return !pmoden;
         6:       return cmd_req && (cmd_sel == 2'd1);
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel);
      int n = 0;
      while (!cond(sel) && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_timeout"}, 32'(cond(sel)), 32'd1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_outs"}, 32'({pmoden, vccen, res_n, cmd_req, cmd_sel,
                              timer_update_match, ready, busy}), 32'b0_0100_0000);
      chk({tag, "_match"}, timer_match, 32'd0);
   endtask

   task automatic pulse(input logic s_start, input logic s_stop);
      start = s_start;
      stop  = s_stop;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic clear_log();
      loads.delete();
      cmds.delete();
      res_low_seen = 1'b0;
   endtask

   task automatic chk_full_log(input string tag);
      int exp_loads[5] = '{5, 2, 2, 7, 9};
      chk({tag, "_nloads"}, 32'(loads.size()), 32'd5);
      if (loads.size() == 5)
         for (int i = 0; i < 5; i++) chk({tag, "_load"}, 32'(loads[i]), 32'(exp_loads[i]));
      chk({tag, "_ncmds"}, 32'(cmds.size()), 32'd2);
      if (cmds.size() == 2) begin
         chk({tag, "_cmd0"}, 32'(cmds[0]), 32'd0);
         chk({tag, "_cmd1"}, 32'(cmds[1]), 32'd1);
      end
   endtask

   initial begin
      // Reset and the first idle cycle afterwards
      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_rst", 32'({timer_update_match, cmd_req, pmoden, busy}), 32'd0);

      // Stop in OFF is ignored
      pulse(1'b0, 1'b1);
      chk("stop_in_off", 32'({pmoden, busy, timer_update_match}), 32'd0);

      // Full power-up
      clear_log();
      pulse(1'b1, 1'b0);
      chk("pmod_entry", 32'({pmoden, busy, timer_update_match, vccen}), 32'b1110);
      chk("pmod_match", timer_match, 32'd5);
      wait_for("up1", 0);
      chk_full_log("up1");
      chk("up1_reslow", 32'(res_low_seen), 32'd1);
      chk("up1_ready", 32'({ready, vccen, busy, pmoden}), 32'b1101);
      @(negedge clk);
      chk("ready_hold", 32'({ready, cmd_req}), 32'b10);

      // Stop in READY
      pulse(1'b0, 1'b1);
      chk("dispoff", 32'({cmd_req, cmd_sel, ready, busy, vccen}), 32'b110011);
      wait_for("vccoff_load", 1);
      chk("vccoff_match", timer_match, 32'd11);
      chk("vccoff_rails", 32'({vccen, pmoden}), 32'b01);
      @(negedge clk);
      wait_for("vccoff_done", 2);
      chk("vccoff_pm_hold", 32'(pmoden), 32'd1);
      @(negedge clk);
      chk("off_entry", 32'({pmoden, busy, ready}), 32'd0);

      // Stop deferred from VCC_WAIT
      pulse(1'b1, 1'b0);
      wait_for("vcc_wait", 4);
      pulse(1'b0, 1'b1);
      chk("stop_deferred", 32'({vccen, ready, cmd_req}), 32'b100);
      wait_for("up2", 0);
      @(negedge clk);
      chk("ready_one_cycle", 32'({ready, cmd_req, cmd_sel}), 32'b0110);
      wait_for("off2", 5);
      chk("off2_busy", 32'(busy), 32'd0);

      // Spurious timer_done in INIT_CMD and cmd_done in VCC_WAIT
      clear_log();
      pulse(1'b1, 1'b0);
      wait_for("init_cmd", 3);
      spur_td = 1'b1;
      @(negedge clk);
      spur_td = 1'b0;
      chk("spur_td", 32'({cmd_req, cmd_sel, vccen, timer_update_match}), 32'b10000);
      chk("spur_td_loads", 32'(loads.size()), 32'd3);
      wait_for("vcc_wait2", 4);
      @(negedge clk);
      spur_cd = 1'b1;
      @(negedge clk);
      spur_cd = 1'b0;
      chk("spur_cd", 32'({vccen, cmd_req, timer_update_match}), 32'b100);
      chk("spur_cd_loads", 32'(loads.size()), 32'd4);
      wait_for("up3", 0);
      chk("up3_nloads", 32'(loads.size()), 32'd5);
      pulse(1'b0, 1'b1);
      wait_for("off3", 5);

      // Reset during DISPON_WAIT, then a full repeat
      pulse(1'b1, 1'b0);
      wait_for("dispon_cmd", 6);
      wait_for("dispon_load", 1);
      chk("dispon_match", timer_match, 32'd9);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_reset("mid_rst");
      @(negedge clk);
      chk("idle_after_rst2", 32'({timer_update_match, cmd_req, pmoden}), 32'd0);
      clear_log();
      pulse(1'b1, 1'b0);
      wait_for("up4", 0);
      chk_full_log("up4");
      pulse(1'b0, 1'b1);
      wait_for("off4", 5);

      // start and stop together in OFF
      pulse(1'b1, 1'b1);
      chk("both_entry", 32'({pmoden, timer_update_match}), 32'b11);
      chk("both_match", timer_match, 32'd5);
      wait_for("up5", 0);
      repeat (3) begin
         @(negedge clk);
         chk("no_pending_stop", 32'({ready, cmd_req}), 32'b10);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
